// File: rtl/wbr_input_cells.sv
// -----------------------------------------------------------------------------
// wbr_input_cells
// -----------------------------------------------------------------------------
// Wrapper boundary register cells for the input side of a wrapped core.
// The cells sit between the chip-level functional inputs (Din) and the core
// inputs (CoreIn). They provide:
//   - a serial scan segment from WPSI to WPSO (LSB exits first),
//   - parallel capture of Din into the shift stage,
//   - an update stage that drives the core while in INTEST,
//   - a shift-length counter whose shift_done pulse tells the wrapper
//     controller that a full WIDTH-bit segment has been shifted.
// In functional and EXTEST modes (intest_en=0) CoreIn is Din combinationally.
//
// Optional feature macro: WBR_SAFE_VALUE_EN
//   Defined     : adds parameter SAFE_VALUE; ur resets to SAFE_VALUE, and
//                 CoreIn is forced to SAFE_VALUE while hold_inputs=1 and
//                 intest_en=1 (ur stays frozen underneath).
//   Not defined : ur resets to 0; hold_inputs only freezes ur.
//
// Ports:
//   CLK            in   1      wrapper clock, rising edge
//   resetn         in   1      asynchronous active-low reset
//   WPSI           in   1      scan serial input (enters sr MSB)
//   wse_inputs     in   1      shift enable
//   capture_inputs in   1      capture Din into sr
//   update_inputs  in   1      load ur from sr
//   hold_inputs    in   1      freeze ur (blocks update_inputs)
//   intest_en      in   1      1: CoreIn from ur, 0: CoreIn = Din
//   Din            in   WIDTH  functional inputs
//   CoreIn         out  WIDTH  inputs to the wrapped core
//   WPSO           out  1      scan serial output (sr[0])
//   shift_done     out  1      one-cycle pulse after WIDTH shifts
// -----------------------------------------------------------------------------
module wbr_input_cells #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH)
`ifdef WBR_SAFE_VALUE_EN
   ,
   parameter logic [WIDTH-1:0] SAFE_VALUE = '0
`endif
) (
   input  logic             CLK,
   input  logic             resetn,
   input  logic             WPSI,
   input  logic             wse_inputs,
   input  logic             capture_inputs,
   input  logic             update_inputs,
   input  logic             hold_inputs,
   input  logic             intest_en,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] CoreIn,
   output logic             WPSO,
   output logic             shift_done
);

`ifdef WBR_SAFE_VALUE_EN
   localparam logic [WIDTH-1:0] UR_RESET = SAFE_VALUE;
`else
   localparam logic [WIDTH-1:0] UR_RESET = '0;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_ur;
   logic [CNT_W-1:0] r_cnt;
   logic             r_shift_done;

   logic [WIDTH-1:0] w_sr_d;
   logic [WIDTH-1:0] w_ur_d;
   logic [CNT_W-1:0] w_cnt_d;
   logic             w_shift_done_d;

   // Shift stage: shift beats capture, otherwise hold.
   always_comb begin
      w_sr_d = r_sr;
      if (wse_inputs) begin
         w_sr_d = {WPSI, r_sr[WIDTH-1:1]};
      end else if (capture_inputs) begin
         w_sr_d = Din;
      end
   end

   // Update stage: a shift in progress or a hold suppresses the update.
   // When update and capture coincide, ur takes the pre-edge sr.
   always_comb begin
      w_ur_d = r_ur;
      if (update_inputs && !wse_inputs && !hold_inputs) begin
         w_ur_d = r_sr;
      end
   end

   // Shift counter: wraps after WIDTH shifts and flags completion for the
   // following cycle; a capture starts a fresh segment.
   always_comb begin
      w_cnt_d        = r_cnt;
      w_shift_done_d = 1'b0;
      if (wse_inputs) begin
         if (r_cnt == CNT_LAST) begin
            w_cnt_d        = '0;
            w_shift_done_d = 1'b1;
         end else begin
            w_cnt_d = r_cnt + 1'b1;
         end
      end else if (capture_inputs) begin
         w_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_sr         <= '0;
         r_ur         <= UR_RESET;
         r_cnt        <= '0;
         r_shift_done <= 1'b0;
      end else begin
         r_sr         <= w_sr_d;
         r_ur         <= w_ur_d;
         r_cnt        <= w_cnt_d;
         r_shift_done <= w_shift_done_d;
      end
   end

   // Core input mux: no register in the functional path.
   always_comb begin
`ifdef WBR_SAFE_VALUE_EN
      if (!intest_en) begin
         CoreIn = Din;
      end else if (hold_inputs) begin
         CoreIn = SAFE_VALUE;
      end else begin
         CoreIn = r_ur;
      end
`else
      CoreIn = intest_en ? r_ur : Din;
`endif
   end

   assign WPSO       = r_sr[0];
   assign shift_done = r_shift_done;

endmodule

// File: tb/tb_wbr_input_cells.sv
module tb_wbr_input_cells;

  localparam int KIND_COREIN = 0;
  localparam int KIND_WPSO   = 1;
  localparam int KIND_DONE   = 2;

`ifdef WBR_SAFE_VALUE_EN
  localparam logic [7:0] HOLD_EXP  = 8'hC3;
  localparam logic [7:0] RESET_UR  = 8'hC3;
`else
  localparam logic [7:0] HOLD_EXP  = 8'h5A;
  localparam logic [7:0] RESET_UR  = 8'h00;
`endif

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } sb_item_t;

  logic       CLK = 1'b0;
  logic       resetn;
  logic       WPSI;
  logic       wse_inputs;
  logic       capture_inputs;
  logic       update_inputs;
  logic       hold_inputs;
  logic       intest_en;
  logic [7:0] Din;
  logic [7:0] CoreIn;
  logic       WPSO;
  logic       shift_done;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  wbr_input_cells #(
    .WIDTH(8)
`ifdef WBR_SAFE_VALUE_EN
    ,
    .SAFE_VALUE(8'hC3)
`endif
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .WPSI          (WPSI),
    .wse_inputs    (wse_inputs),
    .capture_inputs(capture_inputs),
    .update_inputs (update_inputs),
    .hold_inputs   (hold_inputs),
    .intest_en     (intest_en),
    .Din           (Din),
    .CoreIn        (CoreIn),
    .WPSO          (WPSO),
    .shift_done    (shift_done)
  );

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      sb_item_t   it;
      logic [7:0] act;
      it = sb.pop_front();
      case (it.kind)
        KIND_COREIN: act = CoreIn;
        KIND_WPSO:   act = {7'b0, WPSO};
        default:     act = {7'b0, shift_done};
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h (t=%0t)", it.name, act, it.exp, $time);
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [7:0] exp);
    sb_item_t it;
    it.name = name;
    it.kind = kind;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Shift a byte in LSB first; optionally check shift_done after each edge.
  task automatic shift_byte(input logic [7:0] val, input bit chk_done, input string tag);
    for (int i = 0; i < 8; i++) begin
      wse_inputs = 1'b1;
      WPSI       = val[i];
      step(1);
      if (chk_done) expect_val(tag, KIND_DONE, (i == 7) ? 8'd1 : 8'd0);
    end
    wse_inputs = 1'b0;
    WPSI       = 1'b0;
  endtask

  // Shift zeros in while checking the serial output bit stream.
  task automatic shift_out_check(input logic [7:0] exp_bits, input string tag);
    for (int i = 0; i < 8; i++) begin
      expect_val(tag, KIND_WPSO, {7'b0, exp_bits[i]});
      wse_inputs = 1'b1;
      WPSI       = 1'b0;
      step(1);
    end
    wse_inputs = 1'b0;
  endtask

  initial begin
    resetn         = 1'b0;
    WPSI           = 1'b0;
    wse_inputs     = 1'b0;
    capture_inputs = 1'b0;
    update_inputs  = 1'b0;
    hold_inputs    = 1'b0;
    intest_en      = 1'b0;
    Din            = 8'hA5;

    // Reset state
    step(3);
    checks++;
    if (CoreIn !== 8'hA5) begin
      failures++;
      $display("FAIL rst_corein_direct: got %h expected %h", CoreIn, 8'hA5);
    end
    checks++;
    if (WPSO !== 1'b0) begin
      failures++;
      $display("FAIL rst_wpso_direct: got %b expected %b", WPSO, 1'b0);
    end
    checks++;
    if (shift_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_done_direct: got %b expected %b", shift_done, 1'b0);
    end
    expect_val("rst_corein_func", KIND_COREIN, 8'hA5);
    expect_val("rst_wpso", KIND_WPSO, 8'd0);
    expect_val("rst_done", KIND_DONE, 8'd0);
    step(1);
    intest_en = 1'b1;
    expect_val("rst_corein_intest", KIND_COREIN, RESET_UR);
    step(1);
    resetn    = 1'b1;
    intest_en = 1'b0;
    step(1);

    // Shift 8'b1011_0010; shift_done only on the cycle after the 8th edge
    shift_byte(8'b1011_0010, 1'b1, "shift_done_seq");
    step(1);
    expect_val("shift_done_falls", KIND_DONE, 8'd0);
    shift_out_check(8'b1011_0010, "shift_out_b2");

    // Capture Din then shift it out
    Din            = 8'h3C;
    capture_inputs = 1'b1;
    step(1);
    capture_inputs = 1'b0;
    shift_out_check(8'h3C, "capture_out_3c");

    // INTEST update
    shift_byte(8'h5A, 1'b0, "");
    update_inputs = 1'b1;
    step(1);
    update_inputs = 1'b0;
    intest_en     = 1'b1;
    expect_val("intest_5a", KIND_COREIN, 8'h5A);
    step(1);
    hold_inputs = 1'b1;
    shift_byte(8'hFF, 1'b0, "");
    update_inputs = 1'b1;
    step(1);
    update_inputs = 1'b0;
    expect_val("hold_blocks_update", KIND_COREIN, HOLD_EXP);
    step(1);
    hold_inputs = 1'b0;
    expect_val("hold_release_ur", KIND_COREIN, 8'h5A);
    step(1);

    // Shift together with update: update ignored, sr FF -> 7F
    wse_inputs    = 1'b1;
    update_inputs = 1'b1;
    WPSI          = 1'b0;
    step(1);
    wse_inputs    = 1'b0;
    update_inputs = 1'b0;
    expect_val("shift_upd_ur", KIND_COREIN, 8'h5A);
    expect_val("shift_upd_wpso", KIND_WPSO, 8'd1);
    step(1);

    // Capture together with update: ur <- 7F, sr <- 3C
    Din            = 8'h3C;
    capture_inputs = 1'b1;
    update_inputs  = 1'b1;
    step(1);
    capture_inputs = 1'b0;
    update_inputs  = 1'b0;
    expect_val("cap_upd_ur_old_sr", KIND_COREIN, 8'h7F);
    expect_val("cap_upd_wpso", KIND_WPSO, 8'd0);
    step(1);
    update_inputs = 1'b1;
    step(1);
    update_inputs = 1'b0;
    expect_val("cap_upd_sr_din", KIND_COREIN, 8'h3C);
    step(1);
    intest_en = 1'b0;
    Din       = 8'h96;
    expect_val("func_passthru", KIND_COREIN, 8'h96);
    step(1);
    intest_en = 1'b1;

    // Mid-shift asynchronous reset
    Din            = 8'hFF;
    capture_inputs = 1'b1;
    step(1);
    capture_inputs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wse_inputs = 1'b1;
      WPSI       = 1'b1;
      step(1);
    end
    wse_inputs = 1'b0;
    WPSI       = 1'b0;
    expect_val("pre_reset_wpso", KIND_WPSO, 8'd1);
    step(1);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (WPSO !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_wpso_direct: got %b expected %b", WPSO, 1'b0);
    end
    checks++;
    if (CoreIn !== RESET_UR) begin
      failures++;
      $display("FAIL async_rst_ur_direct: got %h expected %h", CoreIn, RESET_UR);
    end
    // Checked at the next falling edge, before any rising edge
    expect_val("async_rst_wpso", KIND_WPSO, 8'd0);
    expect_val("async_rst_ur", KIND_COREIN, RESET_UR);
    expect_val("async_rst_done", KIND_DONE, 8'd0);
    step(2);
    resetn = 1'b1;
    step(1);
    shift_byte(8'h00, 1'b1, "post_rst_shift_done");
    expect_val("post_rst_sr_clear", KIND_WPSO, 8'd0);
    step(1);
    hold_inputs = 1'b1;
    intest_en   = 1'b1;
    expect_val("hold_intest_corein", KIND_COREIN, RESET_UR);
    step(2);
    checks++;
    if (CoreIn !== RESET_UR) begin
      failures++;
      $display("FAIL hold_intest_direct: got %h expected %h", CoreIn, RESET_UR);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/wbr_input_cells.md
Name: wbr_input_cells

Overview:
- IEEE 1500 wrapper boundary register for core inputs: the input-side counterpart of the core-output WBR chain.
- Sits between chip-level functional inputs (Din) and the core's inputs (CoreIn).
- Provides a serial scan segment (WPSI to WPSO), parallel capture of Din, an update stage that drives the core in INTEST, and a shift-length counter for the wrapper controller.
- Transparent in functional and EXTEST modes.

Parameters:
- WIDTH, 8, number of boundary cells (>=2).
- CNT_W, $clog2(WIDTH), width of the shift counter.

Ports:
- CLK  input  1  wrapper clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- WPSI  input  1  parallel-port scan serial input.
- wse_inputs  input  1  shift enable for the input cell chain.
- capture_inputs  input  1  parallel capture of Din into the shift stage.
- update_inputs  input  1  load the update stage from the shift stage.
- hold_inputs  input  1  freeze the update stage; blocks update_inputs.
- intest_en  input  1  1 = CoreIn driven from the update stage; 0 = CoreIn = Din.
- Din  input  WIDTH  functional inputs from pads or the previous block.
- CoreIn  output  WIDTH  inputs to the wrapped core.
- WPSO  output  1  scan serial output, equal to sr[0].
- shift_done  output  1  one-cycle pulse when WIDTH shifts have completed.

Behaviour:
- Registers:
  - sr[WIDTH-1:0]: shift/capture stage.
  - ur[WIDTH-1:0]: update stage.
  - cnt[CNT_W-1:0]: shift counter.
  - shift_done: registered pulse.
- Reset (resetn=0, asynchronous): sr=0, ur=0 (see Optional Feature), cnt=0, shift_done=0. Therefore WPSO=0. CoreIn = Din if intest_en=0, else ur.
- Shift-stage priority each edge:
  1. wse_inputs=1: sr <= {WPSI, sr[WIDTH-1:1]}. WPSI enters the MSB; the LSB exits on WPSO.
  2. Else if capture_inputs=1: sr <= Din, sampled at the edge.
  3. Else: sr holds.
- Update stage:
  - ur <= sr only when update_inputs=1, wse_inputs=0 and hold_inputs=0. Otherwise ur holds.
  - Update and capture asserted in the same cycle: ur takes the old sr and sr takes Din (both in one edge).
  - Update together with shift: update is ignored and the shift proceeds.
- CoreIn: combinational mux, intest_en ? ur : Din. No added latency in functional/EXTEST mode.
- Shift counter:
  - On each shift cycle: cnt increments; at cnt==WIDTH-1 it wraps to 0 and shift_done=1 for the following cycle.
  - shift_done is 0 in all other cycles.
  - capture_inputs=1 without shift clears cnt to 0.
  - cnt holds when idle.
- Latency:
  - Data on WPSI reaches WPSO after WIDTH shift edges.
  - Din captured at edge n is visible on CoreIn (intest_en=1) after an update edge.
- Deasserting wse_inputs mid-chain freezes sr and cnt; shifting resumes where it stopped.
- Reset mid-shift clears sr, ur and cnt immediately. No shift_done pulse results from the aborted sequence.

Optional Feature:
- Macro: WBR_SAFE_VALUE_EN.
- Defined:
  - Adds parameter SAFE_VALUE (WIDTH bits, default all 0).
  - ur resets to SAFE_VALUE.
  - While hold_inputs=1 and intest_en=1, CoreIn = SAFE_VALUE instead of ur; ur is still frozen.
- Not defined:
  - ur resets to 0.
  - hold_inputs only freezes ur; CoreIn = ur in INTEST.

Test Plan (WIDTH=8):
- Reset: resetn=0 for 3 cycles, Din=8'hA5, intest_en=0 -> CoreIn=8'hA5, WPSO=0, shift_done=0. Set intest_en=1 -> CoreIn=8'h00.
- Shift: shift 8'b1011_0010 LSB first, 8 cycles with wse_inputs=1 -> shift_done high exactly on cycle 9 only. A second 8 shifts of zeros then presents WPSO = 0,1,0,0,1,1,0,1.
- Capture: Din=8'h3C, capture_inputs=1 for 1 cycle, then 8 shifts with WPSI=0 -> WPSO = 0,0,1,1,1,1,0,0.
- INTEST update: shift in 8'h5A, pulse update_inputs, intest_en=1 -> CoreIn=8'h5A. Repeat with hold_inputs=1 and 8'hFF shifted -> CoreIn stays 8'h5A (without the macro).
- Collisions: wse_inputs=1 and update_inputs=1 together -> ur unchanged, sr shifts. Capture and update together -> ur gets old sr, sr gets Din.
- Mid-shift reset: after 4 shifts assert resetn=0 asynchronously -> sr=0 and cnt=0 immediately. After release, 8 shifts are needed for shift_done. With WBR_SAFE_VALUE_EN, SAFE_VALUE=8'hC3, hold_inputs=1, intest_en=1 -> CoreIn=8'hC3.
